// File: rtl/hdpldadapt_rx_async_reserved_update.sv
// RX async reserved-bit update: samples SSR reserved bits on each load rise,
// qualifies them over repeated loads and presents the committed value to the PLD.
module hdpldadapt_rx_async_reserved_update #(
  parameter int                  WIDTH        = 3,
  parameter logic [WIDTH-1:0]    RESET_VAL    = {WIDTH{1'b1}},
  parameter int                  STABLE_LOADS = 2
) (
  input  logic             rx_clock_async_rx_osc_clk,
  input  logic             rx_reset_async_rx_osc_clk_rst_n,
  input  logic             rx_async_hssi_fabric_ssr_load,
  input  logic [WIDTH-1:0] rx_async_hssi_fabric_ssr_reserved,
  output logic [WIDTH-1:0] pld_rx_ssr_reserved_out,
  output logic             pld_rx_ssr_reserved_upd
);

  localparam logic [3:0] COMMIT_CNT = 4'(STABLE_LOADS - 1);
  localparam logic [3:0] CNT_MAX    = 4'hf;

  logic             load_q, load_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             upd_q, upd_d;
  logic             load_rise;

  assign load_rise = rx_async_hssi_fabric_ssr_load & ~load_q;

  always_comb begin
    load_d = rx_async_hssi_fabric_ssr_load;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    upd_d  = 1'b0;
    if (load_rise) begin
      if (rx_async_hssi_fabric_ssr_reserved == cand_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd0;
        cand_d = rx_async_hssi_fabric_ssr_reserved;
      end
      // Commit only on a qualified value that actually differs from what the PLD holds.
      if ((cnt_d >= COMMIT_CNT) && (rx_async_hssi_fabric_ssr_reserved != out_q)) begin
        out_d = rx_async_hssi_fabric_ssr_reserved;
        upd_d = 1'b1;
      end
    end
  end

  // load_q resets high so a load already asserted at reset release is not a rise.
  always_ff @(posedge rx_clock_async_rx_osc_clk) begin
    if (!rx_reset_async_rx_osc_clk_rst_n) begin
      load_q <= 1'b1;
      cand_q <= RESET_VAL;
      cnt_q  <= 4'd0;
      out_q  <= RESET_VAL;
      upd_q  <= 1'b0;
    end else begin
      load_q <= load_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      upd_q  <= upd_d;
    end
  end

  assign pld_rx_ssr_reserved_out = out_q;
  assign pld_rx_ssr_reserved_upd = upd_q;

endmodule

// File: tb/tb_hdpldadapt_rx_async_reserved_update.sv
// Scoreboard bench: stimulus pushes expected commits (value, cycle), monitors pop on each upd pulse.
module tb_hdpldadapt_rx_async_reserved_update;

  typedef struct {
    logic [2:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [2:0] data0 = 3'b000, data1 = 3'b000;
  logic [2:0] out0, out1;
  logic       upd0, upd1;
  logic [2:0] prev0, prev1;
  logic       mon_en = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  hdpldadapt_rx_async_reserved_update #(.WIDTH(3), .RESET_VAL(3'b111), .STABLE_LOADS(2)) dut0 (
    .rx_clock_async_rx_osc_clk         (clk),
    .rx_reset_async_rx_osc_clk_rst_n   (rst_n),
    .rx_async_hssi_fabric_ssr_load     (load0),
    .rx_async_hssi_fabric_ssr_reserved (data0),
    .pld_rx_ssr_reserved_out           (out0),
    .pld_rx_ssr_reserved_upd           (upd0)
  );

  hdpldadapt_rx_async_reserved_update #(.WIDTH(3), .RESET_VAL(3'b111), .STABLE_LOADS(1)) dut1 (
    .rx_clock_async_rx_osc_clk         (clk),
    .rx_reset_async_rx_osc_clk_rst_n   (rst_n),
    .rx_async_hssi_fabric_ssr_load     (load1),
    .rx_async_hssi_fabric_ssr_reserved (data1),
    .pld_rx_ssr_reserved_out           (out1),
    .pld_rx_ssr_reserved_upd           (upd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp0(input logic [2:0] v);
    exp_t e;
    e.val = v;
    e.cyc = cyc + 1;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic [2:0] v);
    exp_t e;
    e.val = v;
    e.cyc = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rise0(input logic [2:0] d);
    load0 = 1'b1;
    data0 = d;
    tick();
    load0 = 1'b0;
    tick();
  endtask

  // Monitor for the STABLE_LOADS=2 instance.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (upd0 === 1'b1) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL upd0_unexpected: got pulse with out=%b, expected no pulse (cycle %0d)", out0, cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if (out0 !== e.val || cyc != e.cyc) begin
            fails++;
            $display("FAIL upd0_commit: got out=%b at cycle %0d, expected %b at cycle %0d", out0, cyc, e.val, e.cyc);
          end
        end
      end else if (upd0 !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL upd0_level: got %b, expected 0", upd0);
      end
      if (out0 !== prev0 && upd0 !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL out0_silent_change: got %b, expected %b (cycle %0d)", out0, prev0, cyc);
      end
    end
    prev0 <= out0;
  end

  // Monitor for the STABLE_LOADS=1 instance.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (upd1 === 1'b1) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL upd1_unexpected: got pulse with out=%b, expected no pulse (cycle %0d)", out1, cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (out1 !== e.val || cyc != e.cyc) begin
            fails++;
            $display("FAIL upd1_commit: got out=%b at cycle %0d, expected %b at cycle %0d", out1, cyc, e.val, e.cyc);
          end
        end
      end else if (upd1 !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL upd1_level: got %b, expected 0", upd1);
      end
      if (out1 !== prev1 && upd1 !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL out1_silent_change: got %b, expected %b (cycle %0d)", out1, prev1, cyc);
      end
    end
    prev1 <= out1;
  end

  initial begin
    // 1: reset with load held high, then release with load still high
    rst_n = 1'b0;
    load0 = 1'b1;
    data0 = 3'b000;
    tick();
    tick();
    tick();
    chk("reset_out", {1'b0, out0}, 4'b0111);
    chk("reset_upd", {3'b000, upd0}, 4'b0000);
    chk("reset_out1", {1'b0, out1}, 4'b0111);
    mon_en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_load_out", {1'b0, out0}, 4'b0111);
      chk("held_load_upd", {3'b000, upd0}, 4'b0000);
    end

    // 2: two-load qualification
    load0 = 1'b0;
    tick();
    rise0(3'b010);
    chk("after_first_rise", {1'b0, out0}, 4'b0111);
    load0 = 1'b1;
    data0 = 3'b010;
    exp0(3'b010);
    tick();
    load0 = 1'b0;
    tick();
    chk("after_second_rise_out", {1'b0, out0}, 4'b0010);
    chk("after_second_rise_upd", {3'b000, upd0}, 4'b0000);
    chk("q0_drained_t2", 4'(q0.size()), 4'd0);

    // 3: alternating data never qualifies; a repeat afterwards does
    do_reset();
    load0 = 1'b0;
    tick();
    rise0(3'b010);
    rise0(3'b011);
    rise0(3'b010);
    rise0(3'b011);
    chk("alternate_out", {1'b0, out0}, 4'b0111);
    load0 = 1'b1;
    data0 = 3'b011;
    exp0(3'b011);
    tick();
    load0 = 1'b0;
    tick();
    chk("alternate_then_repeat_out", {1'b0, out0}, 4'b0011);
    chk("q0_drained_t3", 4'(q0.size()), 4'd0);

    // 4: repeats of the current value, then data changing under a held load
    do_reset();
    load0 = 1'b0;
    tick();
    rise0(3'b111);
    rise0(3'b111);
    rise0(3'b111);
    chk("repeat_current_out", {1'b0, out0}, 4'b0111);
    load0 = 1'b1;
    data0 = 3'b001;
    tick();
    data0 = 3'b010;
    tick();
    data0 = 3'b011;
    tick();
    data0 = 3'b100;
    tick();
    data0 = 3'b101;
    tick();
    load0 = 1'b0;
    tick();
    chk("held_load_no_commit", {1'b0, out0}, 4'b0111);
    load0 = 1'b1;
    data0 = 3'b001;
    exp0(3'b001);
    tick();
    load0 = 1'b0;
    tick();
    chk("held_load_sampled_001", {1'b0, out0}, 4'b0001);
    chk("q0_drained_t4", 4'(q0.size()), 4'd0);

    // 5: reset in the middle of qualification
    do_reset();
    load0 = 1'b0;
    tick();
    rise0(3'b100);
    do_reset();
    load0 = 1'b0;
    tick();
    rise0(3'b100);
    chk("reset_mid_no_commit", {1'b0, out0}, 4'b0111);
    load0 = 1'b1;
    data0 = 3'b100;
    exp0(3'b100);
    tick();
    load0 = 1'b0;
    tick();
    chk("reset_mid_commit", {1'b0, out0}, 4'b0100);
    chk("q0_drained_t5", 4'(q0.size()), 4'd0);

    // 6: STABLE_LOADS=1, rises on cycles 0, 2, 4
    load1 = 1'b1;
    data1 = 3'b001;
    exp1(3'b001);
    tick();
    load1 = 1'b0;
    tick();
    load1 = 1'b1;
    data1 = 3'b010;
    exp1(3'b010);
    tick();
    load1 = 1'b0;
    tick();
    load1 = 1'b1;
    data1 = 3'b011;
    exp1(3'b011);
    tick();
    load1 = 1'b0;
    tick();
    chk("sl1_final_out", {1'b0, out1}, 4'b0011);
    rise0(3'b100);
    load1 = 1'b1;
    data1 = 3'b011;
    tick();
    load1 = 1'b0;
    tick();
    chk("sl1_same_value_out", {1'b0, out1}, 4'b0011);
    chk("q1_drained_t6", 4'(q1.size()), 4'd0);
    chk("q0_final", 4'(q0.size()), 4'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_rx_async_reserved_update.md
# hdpldadapt_rx_async_reserved_update

Receive-side counterpart of the TX async reserved capture path. It takes the reserved bits that the sector shift register (SSR) delivers toward the fabric, and samples them on each SSR load strobe. It qualifies each new value by requiring it to repeat over consecutive loads, then drives the committed value to the PLD with a one-cycle update pulse. It sits in the RX channel on the async oscillator clock, between the SSR de-serialiser and the PLD interface.

## Interface
Parameters:
- WIDTH, 3 — number of reserved bits.
- RESET_VAL, 3'b111 — WIDTH-bit reset value of the PLD output and of the candidate register.
- STABLE_LOADS, 2 — number of consecutive identical load samples required before commit; legal range 1..16.

Ports:
- rx_clock_async_rx_osc_clk  in  1  async-path oscillator clock; only clock.
- rx_reset_async_rx_osc_clk_rst_n  in  1  reset, synchronous, active-low.
- rx_async_hssi_fabric_ssr_load  in  1  SSR load level, synchronous to the clock; a 0→1 transition marks a new frame.
- rx_async_hssi_fabric_ssr_reserved  in  WIDTH  parallel reserved bits from the SSR; sampled only in the load-rise cycle.
- pld_rx_ssr_reserved_out  out  WIDTH  committed reserved value to the PLD.
- pld_rx_ssr_reserved_upd  out  1  one-cycle pulse when pld_rx_ssr_reserved_out changes.

## Operation
- State:
  - load_q: previous load level.
  - cand: last sampled value, WIDTH bits.
  - cnt: count of repeats of cand, 4 bits, saturating at 15.
  - out register.
  - upd register.
- load_rise = ssr_load & ~load_q. This is combinational from the input and registered state.
- On each clock edge with load_rise = 1, let s = ssr_reserved:
  - If s == cand, then new_cnt = min(cnt+1, 15).
  - Otherwise, new_cnt = 0 and cand <= s.
  - cnt <= new_cnt.
  - Commit when new_cnt >= STABLE_LOADS-1 and s != out: out <= s and upd <= 1.
- When the commit condition is not met, out holds its value.
- upd is 0 on every edge that does not commit. This makes it exactly one cycle wide, even when commits land on back-to-back load rises.
- With load_rise = 0: cand, cnt and out hold; upd <= 0.
- If a repeated value equals out, the count still advances but nothing commits and upd stays 0.
- STABLE_LOADS = 1: every load rise whose sample differs from out commits immediately.
- Load held high across many cycles: only the rise cycle samples. Data changes while load stays high are ignored.
- Reset, rst_n = 0 at a clock edge:
  - out = RESET_VAL and cand = RESET_VAL.
  - cnt = 0 and upd = 0.
  - load_q = 1. Consequently, a load already high when reset releases produces no rise; a fresh 0→1 transition is required.
- Reset mid-operation discards any partial qualification. Reset is ignored between edges (synchronous).

## Timing
- Input sampling: ssr_reserved is sampled at the rising clock edge that ends the load-rise cycle (cycle N).
- Latency: out and upd change at that same edge and are visible in cycle N+1. This gives one cycle from the qualifying load rise to output.
- Minimum qualification time: STABLE_LOADS load rises. Each rise needs load to spend at least 1 cycle low, so the minimum is 2·STABLE_LOADS−1 cycles from the first qualifying rise.
- No combinational path from any input to any output. All outputs are registered.
- Reset value of every output:
  - pld_rx_ssr_reserved_out = RESET_VAL.
  - pld_rx_ssr_reserved_upd = 0.

## Test plan
All scenarios use the defaults unless noted.
1. **Reset release with load held high.** Assert reset with load = 1 and data = 3'b000, then release reset and hold load = 1 for 10 cycles. Required: out = 3'b111 and upd = 0 throughout.
2. **Two-load qualification.** Apply two load pulses, each 1 cycle high then 1 cycle low, with data = 3'b010. Required: out stays 3'b111 after the first pulse; out = 3'b010 in the cycle after the second rise; upd high for exactly that one cycle.
3. **Alternating data.** Apply load rises with data 010, 011, 010, 011 in sequence. Required: cnt never exceeds 0, out stays 3'b111, and no upd pulse occurs.
4. **Repeat of the current value, and data change under a held load.** Send 3 rises with data = 3'b111, which equals out: required no upd. Then hold load high for 5 cycles while data changes on each cycle, starting at the rise with 3'b001: required only 3'b001 is taken as a sample.
5. **Reset mid-qualification.** After one rise with data 3'b100, pulse reset, then apply one more rise with data 3'b100. Required: no commit. A further rise with 3'b100 then commits.
6. **STABLE_LOADS = 1, back-to-back rises.** Apply rises on cycles 0, 2 and 4 with data 001, 010 and 011. Required: out follows on cycles 1, 3 and 5, and upd pulses on those same cycles.
